serial_transmitter: RTL and testbench

//   Sends one 8-bit control byte {1'b0, Rate[2:0], PR[3:0]} on a two-wire SCL/SDA link.

---
 rtl/serial_transmitter.sv | 127 ++++++++++++
 tb/tb_serial_transmitter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// Two-wire SCL/SDA sender for the {0, Rate, PR} configuration byte.
// SCL is push-pull; SDA is open-drain (driven low or released).
module serial_transmitter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] PR,
    input  logic [2:0] Rate,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]    state;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_idx;
    logic [7:0]    data;
    logic          tick;
    logic          scl;
    logic          sda_low;

    assign tick = (state != S_IDLE) && (qcnt == QW'(CLK_DIV - 1));
    assign busy = (state != S_IDLE);
    assign SCL  = scl;
    assign SDA  = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            qcnt    <= '0;
            quarter <= '0;
            bit_idx <= '0;
            data    <= '0;
            done    <= 1'b0;
            nack    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                qcnt    <= '0;
                quarter <= '0;
                if (start) begin
                    data    <= {1'b0, Rate, PR};
                    nack    <= 1'b0;
                    bit_idx <= '0;
                    state   <= S_START;
                end
            end else if (tick) begin
                qcnt    <= '0;
                quarter <= quarter + 2'd1;
                case (state)
                    S_START: begin
                        // start condition spans two quarters, then slot 0
                        if (quarter == 2'd1) begin
                            state   <= S_DATA;
                            quarter <= '0;
                            bit_idx <= '0;
                        end
                    end
                    S_DATA: begin
                        if (quarter == 2'd3) begin
                            if (bit_idx == 3'd7)
                                state <= S_ACK;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    S_ACK: begin
                        if (quarter == 2'd2)
                            nack <= (SDA !== 1'b0);
                        if (quarter == 2'd3)
                            state <= S_STOP;
                    end
                    S_STOP: begin
                        if (quarter == 2'd3) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else begin
                qcnt <= qcnt + 1'b1;
            end
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state)
            S_START: begin
                scl     = 1'b1;
                sda_low = 1'b1;
            end
            S_DATA: begin
                scl     = quarter[1];
                sda_low = ~data[bit_idx];
            end
            S_ACK: begin
                scl     = quarter[1];
                sda_low = 1'b0;
            end
            S_STOP: begin
                // low through q2, released in q3 while SCL high
                scl     = quarter[1];
                sda_low = (quarter != 2'd3);
            end
            default: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three instances (CLK_DIV 4, 1, 7)
// with bus monitors, ACK responders and per-instance scoreboards.
module tb_serial_transmitter;

    typedef struct {
        logic [7:0] data;
        logic       nack;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v [3];
    logic [3:0] pr_v    [3];
    logic [2:0] rate_v  [3];
    logic       ack_en  [3];
    int         cyc = 0;
    int         nchk = 0;
    int         nerr = 0;
    exp_t       sbq [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 7;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : 7;
        wire        sda;
        logic       scl, busy, done, nack;
        logic       resp_low = 1'b0;
        logic       pscl = 1'b1;
        logic       psda = 1'b1;
        logic [7:0] rx = '0;
        int         rises = 0, starts = 0, stops = 0, blen = 0;
        exp_t       e;

        pullup (sda);
        assign sda = resp_low ? 1'b0 : 1'bz;

        serial_transmitter #(.CLK_DIV(D)) dut (
            .clk  (clk),
            .reset(reset),
            .start(start_v[g]),
            .PR   (pr_v[g]),
            .Rate (rate_v[g]),
            .busy (busy),
            .done (done),
            .nack (nack),
            .SCL  (scl),
            .SDA  (sda)
        );

        always @(negedge clk) begin
            if (reset) begin
                rises = 0; starts = 0; stops = 0; blen = 0;
                resp_low = 1'b0;
            end else begin
                // SDA edges while SCL stays high are start/stop conditions
                if (pscl && scl && sda != psda) begin
                    if (!sda) begin
                        starts++;
                        rises = 0;
                    end else begin
                        stops++;
                    end
                end
                if (!pscl && scl) begin
                    if (rises < 8) rx[rises[2:0]] = sda;
                    rises++;
                end
                if (pscl && !scl)
                    resp_low = (rises == 8) && ack_en[g];
                if (busy) blen++;
                if (done) begin
                    chk($sformatf("u%0d_busy_at_done", g), busy, 0);
                    if (sbq[g].size() == 0) begin
                        chk($sformatf("u%0d_spurious_done", g), sbq[g].size(), 1);
                    end else begin
                        e = sbq[g].pop_front();
                        chk($sformatf("u%0d_byte", g), rx, e.data);
                        chk($sformatf("u%0d_nack", g), nack, e.nack);
                        chk($sformatf("u%0d_done_cyc", g), cyc, e.done_cyc);
                        chk($sformatf("u%0d_starts", g), starts, 1);
                        chk($sformatf("u%0d_stops", g), stops, 1);
                        chk($sformatf("u%0d_scl_rises", g), rises, 10);
                        chk($sformatf("u%0d_busy_len", g), blen, 42 * D);
                    end
                    blen = 0; starts = 0; stops = 0;
                end
            end
            pscl = scl;
            psda = sda;
        end
    end

    task automatic push_exp(input int k, input logic [3:0] pr,
                            input logic [2:0] rate, input logic ack,
                            input int done_cyc);
        exp_t x;
        x.data     = {1'b0, rate, pr};
        x.nack     = ~ack;
        x.done_cyc = done_cyc;
        sbq[k].push_back(x);
    endtask

    task automatic send(input int k, input logic [3:0] pr,
                        input logic [2:0] rate, input logic ack);
        pr_v[k]    = pr;
        rate_v[k]  = rate;
        ack_en[k]  = ack;
        start_v[k] = 1'b1;
        push_exp(k, pr, rate, ack, cyc + 1 + 42 * div_of(k));
        @(negedge clk);
        start_v[k] = 1'b0;
        pr_v[k]    = 4'($urandom);
        rate_v[k]  = 3'($urandom);
    endtask

    task automatic drain(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sbq[k].size() == 0) break;
            @(negedge clk);
        end
        chk($sformatf("u%0d_drain", k), sbq[k].size(), 0);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_scl"},  u[0].scl, 1);
        chk({tag, "_sda"},  u[0].sda, 1);
        chk({tag, "_busy"}, u[0].busy, 0);
        chk({tag, "_done"}, u[0].done, 0);
        chk({tag, "_nack"}, u[0].nack, 0);
    endtask

    initial begin
        int c1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            pr_v[k]    = '0;
            rate_v[k]  = '0;
            ack_en[k]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_chk("por");

        // mid-frame reset aborts without done
        pr_v[0] = 4'h5; rate_v[0] = 3'd2; ack_en[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (60) @(negedge clk);
        chk("mid_busy", u[0].busy, 1);
        reset = 1'b1;
        @(negedge clk);
        idle_chk("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        idle_chk("post_abort");

        // ACKed frame, payload changed after accept
        send(0, 4'hA, 3'd5, 1'b1);
        drain(0, 400);

        // no responder
        send(0, 4'h3, 3'd2, 1'b0);
        drain(0, 400);
        repeat (10) @(negedge clk);
        chk("nack_hold", u[0].nack, 1);

        // start while busy is ignored
        send(0, 4'h6, 3'd1, 1'b1);
        repeat (20) @(negedge clk);
        chk("nack_clr", u[0].nack, 0);
        pr_v[0] = 4'hF; rate_v[0] = 3'd7;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("busy_ign", u[0].busy, 1);
        drain(0, 400);
        repeat (200) @(negedge clk);
        chk("idle_after", u[0].busy, 0);

        // start held: back-to-back frames
        pr_v[0] = 4'h9; rate_v[0] = 3'd3; ack_en[0] = 1'b1;
        start_v[0] = 1'b1;
        c1 = cyc + 1 + 168;
        push_exp(0, 4'h9, 3'd3, 1'b1, c1);
        push_exp(0, 4'h9, 3'd3, 1'b1, c1 + 1 + 168);
        for (int i = 0; i < 500; i++) begin
            if (cyc >= c1 + 1) break;
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        drain(0, 400);

        // other divisors
        for (int n = 0; n < 3; n++) begin
            send(1, 4'($urandom), 3'($urandom), 1'($urandom));
            drain(1, 100);
        end
        send(1, 4'h0, 3'd0, 1'b1);
        drain(1, 100);
        for (int n = 0; n < 2; n++) begin
            send(2, 4'($urandom), 3'($urandom), 1'($urandom));
            drain(2, 700);
        end
        send(2, 4'hF, 3'd7, 1'b0);
        drain(2, 700);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
